// File: rtl/fruit_pkg.sv
// Shared fruit-class definitions for the classifier, the collector and the tally block.
// Also holds the slot layout and the collector state encodings.
package fruit_pkg;

    localparam int CLASS_W = 4;
    localparam logic [CLASS_W-1:0] CLASS_NONE = 4'd0;

    localparam logic [CLASS_W-1:0] FRUIT_APPLE  = 4'd1;
    localparam logic [CLASS_W-1:0] FRUIT_BANANA = 4'd2;
    localparam logic [CLASS_W-1:0] FRUIT_ORANGE = 4'd3;
    localparam logic [CLASS_W-1:0] FRUIT_LEMON  = 4'd4;
    localparam logic [CLASS_W-1:0] FRUIT_PEAR   = 4'd5;
    localparam logic [CLASS_W-1:0] FRUIT_PLUM   = 4'd6;
    localparam logic [CLASS_W-1:0] FRUIT_KIWI   = 4'd7;
    localparam logic [CLASS_W-1:0] FRUIT_MANGO  = 4'd8;
    localparam logic [CLASS_W-1:0] FRUIT_GRAPE  = 4'd9;

    localparam int NSLOT = 4;
    localparam int STABLE_MAX = 15;

    typedef logic [NSLOT-1:0][CLASS_W-1:0] slot_set_t;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        COLLECT   = 2'd1,
        COMMIT    = 2'd2
    } fsm_state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'(STABLE_MAX)) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Normalises vsync polarity and emits a one-cycle pulse when vsync becomes active.
// The pulse is combinational in the cycle the active level is first seen.
module frame_edge_det #(
    parameter bit VS_POL = 1'b1
) (
    input  logic pixelclk,
    input  logic rstin,
    input  logic vsync_in,
    output logic fe
);

    logic vs_n;
    logic vs_d;

    assign vs_n = ~(vsync_in ^ VS_POL);

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= vs_n;
        end
    end

    assign fe = vs_n & ~vs_d;

endmodule

// File: rtl/fruit_sort_collector.sv
// Packs per-frame fruit class codes into four gap-free slots and publishes a set once
// it has repeated for STABLE_FRAMES consecutive frames.
//
// state     | meaning
// WAIT_SYNC | after reset; partial frame, objects ignored until first frame edge
// COLLECT   | filling slots; frame edge snapshots slots into cand
// COMMIT    | one cycle: compare cand with previous set, maybe publish
module fruit_sort_collector
    import fruit_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter bit VS_POL        = 1'b1
) (
    input  logic               pixelclk,
    input  logic               rstin,
    input  logic               vsync_in,
    input  logic               obj_valid,
    input  logic [CLASS_W-1:0] obj_class,
    output logic [CLASS_W-1:0] sort,
    output logic [CLASS_W-1:0] sort1,
    output logic [CLASS_W-1:0] sort2,
    output logic [CLASS_W-1:0] sort3,
    output logic               update,
    output logic               overflow
);

    localparam logic [2:0] PTR_FULL  = 3'(NSLOT);
    localparam logic [3:0] STABLE_TC = 4'(STABLE_FRAMES);

    fsm_state_t state;
    fsm_state_t state_nxt;

    logic       fe;
    logic       fe_pend;
    logic       close;
    logic       obj_ok;

    slot_set_t  slots;
    logic [2:0] wr_ptr;
    logic       frame_ovf;

    slot_set_t  cand;
    logic       cand_ovf;
    slot_set_t  prev;
    logic [3:0] stable_cnt;
    logic       cand_match;
    logic [3:0] cnt_nxt;
    logic       publish;

    frame_edge_det #(
        .VS_POL (VS_POL)
    ) u_frame_edge_det (
        .pixelclk (pixelclk),
        .rstin    (rstin),
        .vsync_in (vsync_in),
        .fe       (fe)
    );

    // An edge landing in COMMIT is deferred and closes the frame on the next cycle.
    assign close  = (state == COLLECT) && (fe || fe_pend);
    assign obj_ok = obj_valid && (obj_class != CLASS_NONE);

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SYNC: if (fe) state_nxt = COLLECT;
            COLLECT:   if (close) state_nxt = COMMIT;
            COMMIT:    state_nxt = COLLECT;
            default:   state_nxt = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            fe_pend <= 1'b0;
        end else begin
            fe_pend <= (state == COMMIT) && fe;
        end
    end

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            slots     <= '0;
            wr_ptr    <= 3'd0;
            frame_ovf <= 1'b0;
            cand      <= '0;
            cand_ovf  <= 1'b0;
        end else if (state == WAIT_SYNC) begin
            if (fe) begin
                slots     <= '0;
                wr_ptr    <= 3'd0;
                frame_ovf <= 1'b0;
            end
        end else if (close) begin
            cand      <= slots;
            cand_ovf  <= frame_ovf;
            slots     <= '0;
            frame_ovf <= 1'b0;
            // An object in the edge cycle already belongs to the new frame.
            if (obj_ok) begin
                slots[0] <= obj_class;
                wr_ptr   <= 3'd1;
            end else begin
                wr_ptr   <= 3'd0;
            end
        end else if (obj_ok) begin
            if (wr_ptr != PTR_FULL) begin
                slots[wr_ptr[1:0]] <= obj_class;
                wr_ptr             <= wr_ptr + 3'd1;
            end else begin
                frame_ovf <= 1'b1;
            end
        end
    end

    assign cand_match = (cand == prev);
    assign cnt_nxt    = cand_match ? sat_inc(stable_cnt) : 4'd1;
    // A saturated run keeps cnt_nxt == stable_cnt; only the first arrival publishes.
    assign publish    = (state == COMMIT) && (cnt_nxt == STABLE_TC) &&
                        !(cand_match && (stable_cnt == STABLE_TC));

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            prev       <= '0;
            stable_cnt <= 4'd0;
            sort       <= CLASS_NONE;
            sort1      <= CLASS_NONE;
            sort2      <= CLASS_NONE;
            sort3      <= CLASS_NONE;
            overflow   <= 1'b0;
            update     <= 1'b0;
        end else begin
            update <= 1'b0;
            if (state == COMMIT) begin
                stable_cnt <= cnt_nxt;
                if (!cand_match) begin
                    prev <= cand;
                end
                if (publish) begin
                    sort     <= cand[0];
                    sort1    <= cand[1];
                    sort2    <= cand[2];
                    sort3    <= cand[3];
                    overflow <= cand_ovf;
                    update   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fruit_sort_collector.sv
// Directed bench for fruit_sort_collector: a frame model pushes expected publishes
// (set, overflow, cycle) to a scoreboard that is popped on every update pulse.
module tb_fruit_sort_collector;
    import fruit_pkg::*;

    localparam int STABLE = 3;

    logic       pixelclk = 1'b0;
    logic       rstin = 1'b0;
    logic       vsync_in = 1'b0;
    logic       obj_valid = 1'b0;
    logic [3:0] obj_class = 4'd0;
    logic [3:0] sort, sort1, sort2, sort3;
    logic       update, overflow;

    fruit_sort_collector #(
        .STABLE_FRAMES (STABLE),
        .VS_POL        (1'b1)
    ) dut (
        .pixelclk  (pixelclk),
        .rstin     (rstin),
        .vsync_in  (vsync_in),
        .obj_valid (obj_valid),
        .obj_class (obj_class),
        .sort      (sort),
        .sort1     (sort1),
        .sort2     (sort2),
        .sort3     (sort3),
        .update    (update),
        .overflow  (overflow)
    );

    always #5 pixelclk = ~pixelclk;

    int cyc = 0;
    always @(posedge pixelclk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] set;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    bit         m_wait = 1'b1;
    logic [3:0] m_cur[$];
    bit         m_ovf = 1'b0;
    logic [15:0] m_prev = 16'h0;
    int         m_run = 0;

    always @(negedge pixelclk) begin
        exp_t e;
        if (rstin === 1'b1 && update === 1'b1) begin
            vectors++;
            assert (sb.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_update cycle=%0d observed=%h expected=no_update", cyc, {sort3, sort2, sort1, sort});
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                assert ({sort3, sort2, sort1, sort, overflow} === {e.set, e.ovf}) else begin
                    miscompares++;
                    $error("FAIL publish_value observed=%h/%b expected=%h/%b", {sort3, sort2, sort1, sort}, overflow, e.set, e.ovf);
                end
                vectors++;
                assert (cyc === e.cyc) else begin
                    miscompares++;
                    $error("FAIL publish_latency observed=%0d expected=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic model_obj(input logic [3:0] c);
        if (!m_wait && c != 4'd0) begin
            if (m_cur.size() < 4) m_cur.push_back(c);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic obj(input logic [3:0] c);
        obj_valid = 1'b1;
        obj_class = c;
        model_obj(c);
        step();
        obj_valid = 1'b0;
        obj_class = 4'd0;
        step();
    endtask

    task automatic frame_edge(input bit with_obj, input logic [3:0] c);
        logic [15:0] cand;
        int n;
        n = cyc;
        vsync_in = 1'b1;
        if (with_obj) begin
            obj_valid = 1'b1;
            obj_class = c;
        end
        if (m_wait) begin
            m_wait = 1'b0;
            m_cur.delete();
            m_ovf = 1'b0;
        end else begin
            cand = 16'h0;
            for (int i = 0; i < m_cur.size(); i++) cand[i*4 +: 4] = m_cur[i];
            if (cand == m_prev) begin
                m_run++;
            end else begin
                m_run = 1;
                m_prev = cand;
            end
            if (m_run == STABLE) sb.push_back('{cand, m_ovf, n + 2});
            m_cur.delete();
            m_ovf = 1'b0;
            if (with_obj) model_obj(c);
        end
        step();
        obj_valid = 1'b0;
        obj_class = 4'd0;
        step();
        step();
        vsync_in = 1'b0;
        step();
    endtask

    task automatic frame(input int n, input logic [23:0] codes, input bit eobj, input logic [3:0] ec);
        for (int i = 0; i < n; i++) obj(codes[i*4 +: 4]);
        repeat (2) step();
        frame_edge(eobj, ec);
        repeat (2) step();
    endtask

    task automatic check_hold(input string tag, input logic [15:0] eset, input logic eovf);
        vectors++;
        assert ({sort3, sort2, sort1, sort, overflow} === {eset, eovf}) else begin
            miscompares++;
            $error("FAIL %s observed=%h/%b expected=%h/%b", tag, {sort3, sort2, sort1, sort}, overflow, eset, eovf);
        end
    endtask

    initial begin
        repeat (3) step();
        vectors++;
        assert ({sort3, sort2, sort1, sort, update, overflow} === 18'h0) else begin
            miscompares++;
            $error("FAIL reset_state observed=%h expected=0", {sort3, sort2, sort1, sort, update, overflow});
        end
        #3 rstin = 1'b1;
        step();

        // objects before the first vsync are a partial frame
        obj(4'd2);
        obj(4'd3);
        frame_edge(1'b0, 4'd0);
        repeat (3) frame(2, 24'h000021, 1'b0, 4'd0);
        check_hold("first_set", 16'h0021, 1'b0);

        repeat (2) frame(3, 24'h000311, 1'b0, 4'd0);
        frame(3, 24'h000131, 1'b0, 4'd0);
        check_hold("run_reset_hold", 16'h0021, 1'b0);
        repeat (3) frame(3, 24'h000131, 1'b0, 4'd0);
        check_hold("order_change", 16'h0131, 1'b0);

        repeat (3) frame(5, 24'h060504, 1'b0, 4'd0);
        check_hold("gap_free", 16'h0654, 1'b0);

        repeat (3) frame(6, 24'h654321, 1'b0, 4'd0);
        check_hold("overflow_set", 16'h4321, 1'b1);
        repeat (3) frame(1, 24'h000007, 1'b0, 4'd0);
        check_hold("overflow_clear", 16'h0007, 1'b0);

        repeat (3) frame(1, 24'h000008, 1'b1, 4'd9);
        frame(1, 24'h000008, 1'b0, 4'd0);
        check_hold("edge_cycle_obj", 16'h0089, 1'b0);

        repeat (10) frame(4, 24'h002222, 1'b0, 4'd0);
        check_hold("saturate_single", 16'h2222, 1'b0);

        obj(4'd5);
        #2 rstin = 1'b0;
        #1;
        vectors++;
        assert ({sort3, sort2, sort1, sort, update, overflow} === 18'h0) else begin
            miscompares++;
            $error("FAIL async_reset observed=%h expected=0", {sort3, sort2, sort1, sort, update, overflow});
        end
        m_wait = 1'b1;
        m_cur.delete();
        m_ovf = 1'b0;
        m_prev = 16'h0;
        m_run = 0;
        repeat (2) step();
        #3 rstin = 1'b1;
        step();
        obj(4'd5);
        frame_edge(1'b0, 4'd0);
        repeat (4) step();
        check_hold("post_reset_open", 16'h0000, 1'b0);
        repeat (3) frame(1, 24'h000005, 1'b0, 4'd0);
        check_hold("post_reset_publish", 16'h0005, 1'b0);

        repeat (10) step();
        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL missing_update observed=%0d_pending expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fruit_sort_collector.md
Name: fruit_sort_collector

Overview:
- Producer side of the fruit-tally path. Collects per-object class codes from the classifier during one video frame and packs them, in arrival order, into four slots.
- After a code set has been identical for STABLE_FRAMES consecutive frames, publishes it on sort/sort1/sort2/sort3 for the downstream tally/display block.
- Gap-free packing (a zero slot is never followed by a non-zero slot) is the contract the downstream tally relies on.

Parameters:
- STABLE_FRAMES, 3, consecutive identical frames required before publish (range 1..15).
- VS_POL, 1, active level of vsync_in (1 = active-high).

Ports:
- pixelclk  in  1  pixel clock; all logic on rising edge
- rstin  in  1  asynchronous active-low reset
- vsync_in  in  1  frame sync from the video timing chain
- obj_valid  in  1  one-cycle strobe: obj_class is valid
- obj_class  in  4  fruit class code; 0 = no fruit / background
- sort  out  4  published slot 0 (first object of the frame)
- sort1  out  4  published slot 1
- sort2  out  4  published slot 2
- sort3  out  4  published slot 3
- update  out  1  one-cycle pulse when sort..sort3 are re-published
- overflow  out  1  sticky per published set: the source frame had more than 4 objects

Behaviour:
- Reset values (async, while rstin=0): sort..sort3=0, update=0, overflow=0, slots=0, wr_ptr=0, stable_cnt=0, prev set=0, state=WAIT_SYNC.
- Frame edge (fe):
  - vs_n = vsync_in XNOR VS_POL, i.e. 1 when vsync is active.
  - vs_d = vs_n registered.
  - fe = vs_n & ~vs_d (combinational in cycle T).
- State WAIT_SYNC: objects ignored (partial frame after reset). On fe -> COLLECT; clear slots, wr_ptr=0.
- State COLLECT:
  - obj_valid=1 and obj_class!=0 and wr_ptr<4: slot[wr_ptr]<=obj_class, wr_ptr++.
  - obj_valid=1 and obj_class=0: ignored.
  - obj_valid=1 and wr_ptr=4: object dropped, frame_ovf<=1.
- Frame close on fe in COLLECT, cycle T:
  - cand<=slots, cand_ovf<=frame_ovf.
  - Slots cleared, wr_ptr reset, frame_ovf cleared.
  - An object valid in cycle T belongs to the NEW frame: written to slot 0, wr_ptr=1.
  - Next state COMMIT.
- State COMMIT, cycle T+1 (one cycle):
  - If cand == prev: stable_cnt<=sat(stable_cnt+1, 15). Otherwise stable_cnt<=1 and prev<=cand.
  - Publish when the new stable_cnt value == STABLE_FRAMES exactly.
  - On publish, registered at end of T+1 and visible at T+2: sort..sort3<=cand, overflow<=cand_ovf, update=1 for that single cycle.
  - Publishes once per stable run. A continuing identical run past STABLE_FRAMES does not re-pulse update.
  - Objects arriving in T+1 are collected normally.
  - Next state COLLECT.
- fe while in COMMIT: impossible in practice (vsync period far exceeds 2 cycles), but defined: treated as fe in COLLECT during the following cycle.
- Packing: slots fill in order; zero slots only at the tail.
- An empty frame gives cand=0000. If stable, it is published as all zeros; the downstream block then holds its previous display.
- Outputs hold between publishes. No combinational path from inputs to outputs.
- Reset mid-frame: all state cleared immediately. The first frame edge after release only opens collection; it does not commit.
- Latency: frame edge cycle T -> update pulse at T+2, for a set that reaches stability on that frame.

Decomposition:
- Shared package fruit_pkg:
  - CLASS_W=4 and CLASS_NONE=4'd0.
  - Fruit class code constants, shared with the classifier and the tally block.
  - Slot count NSLOT=4.
  - State encodings WAIT_SYNC/COLLECT/COMMIT.
- One natural sub-module: frame_edge_det, the vsync polarity normalise plus rising-edge pulse, reusable by other ISP blocks.
- Slot fill, compare and publish stay in the top module.

Test Plan:
- Reset release, then objects 2,3 before the first vsync, then 3 identical frames of {1,2} -> frames before the first vsync ignored; sort=1, sort1=2, sort2=0, sort3=0; update pulses once, 2 cycles after the 3rd closing edge; overflow=0.
- Frames {1,1,3}, {1,1,3}, {1,3,1}, then {1,3,1}x3 -> no publish on the 3rd frame (run reset); publish 1,3,1,0 only after 3 consecutive {1,3,1} frames.
- Frame with objects 4,0,5,0,6 (class 0 interleaved), x3 -> published 4,5,6,0 with no gaps.
- Six objects 1,2,3,4,5,6 per frame, x3 -> published 1,2,3,4; overflow=1. Then 3 frames of {7} -> 7,0,0,0; overflow=0.
- obj_valid (class 9) in exactly the fe cycle -> 9 excluded from the closing frame and appears as slot 0 of the next frame.
- 10 identical frames {2,2,2,2} -> a single update pulse; sort..sort3=2; stable_cnt saturates. Assert rstin mid-frame -> all outputs 0 asynchronously, and the next frame edge re-enters collection without a publish.
